code_loader: RTL and testbench

Sequential writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them to consecutive code-memory addresses starting at 0. Sits between the host/boot link and the write port of the instruction store, and holds the pipeline (`cpu_hold`) while a program image is being loaded. It is the producer side of the pc→instr read path: it fills the words that fetch later reads.

---
 rtl/code_loader_pkg.sv | 32 +++
 rtl/code_loader_byte_packer.sv | 42 ++++
 rtl/code_loader.sv | 175 +++++++++++++++++
 tb/tb_code_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_loader_pkg.sv
// code_loader_pkg: shared definitions for the instruction-memory loader.
// Contents: loader FSM state encoding, stream framing constants
// (LEN_BYTES, BYTES_PER_WORD, WORD_W) and small state-decode helpers.
package code_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = LEN_BYTES * BYTE_W;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // States in which the loader takes bytes from the stream.
  function automatic logic is_receiving(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

  // States in which the pipeline must stay frozen.
  function automatic logic holds_cpu(input state_t s);
    return is_receiving(s) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/code_loader_byte_packer.sv
// byte_packer: assembles big-endian instruction words from a byte stream.
// Ports:
//   clk, rst          clock, async active-high reset
//   clr               restart word assembly at byte 0
//   byte_valid        byte_data is accepted this cycle
//   byte_data         stream byte (first byte of a word -> bits 31:24)
//   word_valid_c      combinational: this byte completes a word
//   word_c            combinational: completed word (valid with word_valid_c)
module byte_packer
  import code_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [BYTE_CNT_W-1:0]    cnt_q;
  logic [WORD_W-BYTE_W-1:0] sr_q;

  // Byte position within the word and the upper bytes collected so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + BYTE_CNT_W'(1);
      sr_q  <= {sr_q[WORD_W-2*BYTE_W-1:0], byte_data};
    end
  end

  // The last byte is used straight from the input so the word is ready in
  // the handshake cycle and the top can register the write one cycle later.
  assign word_valid_c = byte_valid && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word_c       = {sr_q, byte_data};

endmodule

// File: rtl/code_loader.sv
// code_loader: streams a program image into the instruction memory.
// Stream: 16-bit word count N (MSB first), then N big-endian 32-bit words,
// written to consecutive word addresses from 0 while cpu_hold is asserted.
// Optional feature macro CODE_LOADER_CHECKSUM_EN: a trailing XOR checksum
// byte over all data bytes is required; mismatch ends in the error state.
// Ports:
//   clk, rst               clock, async active-high reset
//   start                  begin a load (honoured in IDLE, DONE, ERR)
//   in_valid/in_data       byte stream input, in_ready back-pressure
//   mem_we/mem_addr/mem_wdata  one-cycle code-memory write port
//   cpu_hold               stall the pipeline while loading or failed
//   done/error             level status of the last load
//   words_loaded           words written by the current/last load
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned LEN_CNT_W = $clog2(LEN_BYTES);

  state_t                  state_q, state_d;
  logic [LEN_CNT_W-1:0]    len_cnt_q;
  logic [LEN_W-BYTE_W-1:0] len_sr_q;
  logic [CNT_W-1:0]        len_q;
  logic                    accept_c;
  logic                    start_c;
  logic                    len_last_c;
  logic                    last_word_c;
  logic                    pack_valid_c;
  logic                    word_valid_c;
  logic [LEN_W-1:0]        len_word_c;
  logic [WORD_W-1:0]       word_c;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]       chk_q;
`endif

  assign accept_c     = in_valid && in_ready;
  assign len_word_c   = {len_sr_q, in_data};
  assign len_last_c   = (len_cnt_q == LEN_CNT_W'(LEN_BYTES - 1));
  assign pack_valid_c = accept_c && (state_q == ST_DATA);
  // N never exceeds DEPTH here, so the count cannot overflow CNT_W bits.
  assign last_word_c  = ((words_loaded + CNT_W'(1)) == len_q);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr          (start_c),
    .byte_valid   (pack_valid_c),
    .byte_data    (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State register plus status outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      in_ready <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= is_receiving(state_d);
      cpu_hold <= holds_cpu(state_d);
      done     <= (state_d == ST_DONE);
      error    <= (state_d == ST_ERR);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
          start_c = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept_c && len_last_c) begin
          if (len_word_c == '0) begin
            state_d = ST_DONE;
          end else if (32'(len_word_c) > DEPTH) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid_c && last_word_c) begin
`ifdef CODE_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept_c) begin
          state_d = (in_data == chk_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Length capture, write port and word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt_q    <= '0;
      len_sr_q     <= '0;
      len_q        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_c) begin
        len_cnt_q    <= '0;
        words_loaded <= '0;
      end
      if (accept_c && (state_q == ST_LEN)) begin
        len_cnt_q <= len_last_c ? '0 : len_cnt_q + LEN_CNT_W'(1);
        len_sr_q  <= len_word_c[LEN_W-BYTE_W-1:0];
        if (len_last_c) begin
          len_q <= CNT_W'(len_word_c);
        end
      end
      if (word_valid_c) begin
        mem_we       <= 1'b1;
        mem_addr     <= ADDR_W'(words_loaded);
        mem_wdata    <= word_c;
        words_loaded <= words_loaded + CNT_W'(1);
      end
    end
  end

`ifdef CODE_LOADER_CHECKSUM_EN
  // Running XOR over every data byte of the current load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else if (start_c) begin
      chk_q <= '0;
    end else if (pack_valid_c) begin
      chk_q <= chk_q ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: directed self-checking bench for code_loader (ADDR_W=8).
// Covers reset values, N=3 load with write timing, N=0, N=257 overflow,
// a gapped N=2 load with an ignored mid-load start, N=256 boundary,
// reset during a load and, with CODE_LOADER_CHECKSUM_EN, checksum pass/fail.
module tb_code_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]        chk_acc;
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  logic [31:0]       w3[3] = '{32'h0422_1800, 32'h04A4_0800, 32'h04E6_0800};
  logic [31:0]       wq[$];

  always #5 clk = ~clk;

  code_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // Present one byte and return 1 time unit after the edge that takes it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int b = 3; b >= 0; b--) begin
      chk_acc = chk_acc ^ w[8*b +: 8];
      send_byte(w[8*b +: 8], gaps);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_start(input string tag);
    pulse_start();
    chk_acc = 8'h00;
    clear_log();
    check({tag, "_start_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_start_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_start_done"}, 64'(done), 64'd0);
    check({tag, "_start_error"}, 64'(error), 64'd0);
    check({tag, "_start_count"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_count"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    int bad;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk_acc  = 8'h00;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // N=3, back-to-back bytes; each write lands the cycle after its 4th byte.
    do_start("n3");
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word(w3[i], 1'b0);
      check($sformatf("n3_we_%0d", i), 64'(mem_we), 64'd1);
      check($sformatf("n3_addr_%0d", i), 64'(mem_addr), 64'(i));
      check($sformatf("n3_wdata_%0d", i), 64'(mem_wdata), 64'(w3[i]));
      check($sformatf("n3_count_%0d", i), 64'(words_loaded), 64'(i + 1));
      if (i < 2) check($sformatf("n3_busy_%0d", i), 64'(done), 64'd0);
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    check("n3_wait_chk", 64'(done), 64'd0);
    send_byte(chk_acc, 1'b0);
`endif
    check("n3_done", 64'(done), 64'd1);
    check("n3_hold", 64'(cpu_hold), 64'd0);
    check("n3_ready", 64'(in_ready), 64'd0);
    check("n3_error", 64'(error), 64'd0);
    check("n3_count", 64'(words_loaded), 64'd3);
    tick();
    check("n3_we_one_cycle", 64'(mem_we), 64'd0);
    check("n3_done_level", 64'(done), 64'd1);
    check("n3_log_size", 64'(log_addr.size()), 64'd3);
    for (int i = 0; i < log_addr.size() && i < 3; i++) begin
      check($sformatf("n3_log_addr_%0d", i), 64'(log_addr[i]), 64'(i));
      check($sformatf("n3_log_data_%0d", i), 64'(log_data[i]), 64'(w3[i]));
    end

    // N=0: straight to DONE, nothing written.
    do_start("n0");
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("n0_done", 64'(done), 64'd1);
    check("n0_hold", 64'(cpu_hold), 64'd0);
    check("n0_count", 64'(words_loaded), 64'd0);
    tick();
    check("n0_no_writes", 64'(log_addr.size()), 64'd0);

    // N=257 exceeds the 256-word store.
    do_start("n257");
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("n257_error", 64'(error), 64'd1);
    check("n257_done", 64'(done), 64'd0);
    check("n257_ready", 64'(in_ready), 64'd0);
    check("n257_hold", 64'(cpu_hold), 64'd1);
    repeat (2) tick();
    check("n257_error_level", 64'(error), 64'd1);
    check("n257_no_writes", 64'(log_addr.size()), 64'd0);

    // N=2 with random gaps; a start pulse mid-load must be ignored.
    do_start("gap");
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    pulse_start();
    check("gap_start_ignored_count", 64'(words_loaded), 64'd1);
    check("gap_start_ignored_ready", 64'(in_ready), 64'd1);
    send_word(32'h1234_5678, 1'b1);
`ifdef CODE_LOADER_CHECKSUM_EN
    send_byte(chk_acc, 1'b1);
`endif
    check("gap_done", 64'(done), 64'd1);
    check("gap_count", 64'(words_loaded), 64'd2);
    tick();
    check("gap_log_size", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      check("gap_log_addr0", 64'(log_addr[0]), 64'd0);
      check("gap_log_data0", 64'(log_data[0]), 64'h0000_0000_DEAD_BEEF);
      check("gap_log_addr1", 64'(log_addr[1]), 64'd1);
      check("gap_log_data1", 64'(log_data[1]), 64'h0000_0000_1234_5678);
    end

    // N=256: fills the store exactly, last write at address 255.
    wq.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] i8;
      i8 = 8'(i);
      wq.push_back({i8, ~i8, i8 ^ 8'h5A, 8'hC3});
    end
    do_start("n256");
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    foreach (wq[i]) send_word(wq[i], 1'b0);
`ifdef CODE_LOADER_CHECKSUM_EN
    send_byte(chk_acc, 1'b0);
`endif
    check("n256_done", 64'(done), 64'd1);
    check("n256_count", 64'(words_loaded), 64'd256);
    check("n256_last_addr", 64'(mem_addr), 64'd255);
    tick();
    check("n256_log_size", 64'(log_addr.size()), 64'd256);
    bad = 0;
    for (int i = 0; i < log_addr.size() && i < 256; i++) begin
      if (log_addr[i] !== 8'(i) || log_data[i] !== wq[i]) bad++;
    end
    check("n256_log_entries", 64'(bad), 64'd0);

    // Reset after 6 data bytes of an N=4 load.
    do_start("rstmid");
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("rstmid_async");
    tick();
    check_all_zero("rstmid_held");
    rst = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) tick();
    check("rstmid_idle_ready", 64'(in_ready), 64'd0);
    check("rstmid_idle_hold", 64'(cpu_hold), 64'd0);
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("rstmid_log_size", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() == 1) begin
      check("rstmid_log_addr", 64'(log_addr[0]), 64'd0);
      check("rstmid_log_data", 64'(log_data[0]), 64'h0000_0000_1122_3344);
    end

`ifdef CODE_LOADER_CHECKSUM_EN
    // Checksum 0x01^0x02^0x03^0x04 = 0x04.
    do_start("chk_ok");
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'h0102_0304, 1'b0);
    check("chk_ok_wait", 64'(done), 64'd0);
    send_byte(8'h04, 1'b0);
    check("chk_ok_done", 64'(done), 64'd1);
    check("chk_ok_error", 64'(error), 64'd0);

    do_start("chk_bad");
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'h0102_0304, 1'b0);
    send_byte(8'h05, 1'b0);
    check("chk_bad_error", 64'(error), 64'd1);
    check("chk_bad_done", 64'(done), 64'd0);
    check("chk_bad_hold", 64'(cpu_hold), 64'd1);
    tick();
    check("chk_bad_log_size", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() == 1) begin
      check("chk_bad_log_addr", 64'(log_addr[0]), 64'd0);
      check("chk_bad_log_data", 64'(log_data[0]), 64'h0000_0000_0102_0304);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
